fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 40 ++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcode field position, opcodes and fetch FSM encodings.
package fetch_unit_pkg;

   localparam int unsigned FU_PC_WIDTH    = 16;
   localparam int unsigned FU_INSTR_WIDTH = 16;
   localparam int unsigned FU_PC_STEP     = 1;
   localparam int unsigned FU_COUNT_WIDTH = 16;
   localparam logic [15:0] FU_RESET_PC    = 16'h0000;

   // Opcode occupies the top nibble of the instruction word.
   localparam int unsigned OPC_MSB   = 15;
   localparam int unsigned OPC_LSB   = 12;
   localparam int unsigned OPC_WIDTH = 4;

   localparam logic [3:0] OPC_ADD  = 4'h0;
   localparam logic [3:0] OPC_SUB  = 4'h1;
   localparam logic [3:0] OPC_AND  = 4'h2;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // Fetch FSM state encodings.
   localparam logic [1:0] ST_REQ    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction and its address.
module fetch_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [ADDR_W-1:0] i_pc,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_pc
);

   logic              r_valid;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_pc;

   // Load wins over clear; clearing only drops valid so the payload stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem, hands words to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned         PC_WIDTH    = FU_PC_WIDTH,
   parameter int unsigned         INSTR_WIDTH = FU_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(FU_RESET_PC),
   parameter int unsigned         PC_STEP     = FU_PC_STEP
) (
   input  logic                      clk,
   input  logic                      rst_n,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic                      imem_ack,
   input  logic [INSTR_WIDTH-1:0]    imem_rdata,
   output logic                      id_valid,
   input  logic                      id_ready,
   output logic [INSTR_WIDTH-1:0]    id_instr,
   output logic [OPC_WIDTH-1:0]      id_opcode,
   output logic [PC_WIDTH-1:0]       id_pc,
   input  logic                      pc_write,
   input  logic                      redirect_valid,
   input  logic [PC_WIDTH-1:0]       redirect_pc,
   output logic                      halted,
   output logic [FU_COUNT_WIDTH-1:0] fetch_count
);

   logic [1:0]                r_state;
   logic [PC_WIDTH-1:0]       r_pc;
   logic [PC_WIDTH-1:0]       r_addr;
   logic                      r_req;
   logic                      r_halted;
   logic [FU_COUNT_WIDTH-1:0] r_count;

   logic [1:0]                w_state_nxt;
   logic [PC_WIDTH-1:0]       w_pc_nxt;
   logic [PC_WIDTH-1:0]       w_addr_nxt;
   logic                      w_req_nxt;
   logic                      w_load;
   logic                      w_clear;
   logic                      w_count_inc;
   logic                      w_ack;
   logic                      w_hs;
   logic                      w_buf_valid;

   // An ack only counts against a request we are actually driving.
   assign w_ack    = r_req & imem_ack;
   assign id_valid = w_buf_valid & ~redirect_valid;
   assign w_hs     = id_valid & id_ready;

   fetch_buffer #(
      .DATA_W (INSTR_WIDTH),
      .ADDR_W (PC_WIDTH)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_instr (imem_rdata),
      .i_pc    (r_pc),
      .o_valid (w_buf_valid),
      .o_instr (id_instr),
      .o_pc    (id_pc)
   );

   assign id_opcode = id_instr[OPC_MSB:OPC_LSB];

   // Next-state logic: redirect beats halt beats normal fetch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      w_count_inc = 1'b0;
      case (r_state)
         ST_REQ: begin
            if (redirect_valid) begin
               w_pc_nxt    = redirect_pc;
               w_clear     = 1'b1;
               // An outstanding unacked request must run to completion.
               w_state_nxt = (r_req & ~imem_ack) ? ST_DRAIN : ST_REQ;
            end else if (w_ack) begin
               w_load      = 1'b1;
               w_pc_nxt    = r_pc + PC_WIDTH'(PC_STEP);
               w_state_nxt = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) begin
               w_pc_nxt = redirect_pc;
            end
            if (w_ack) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               w_pc_nxt    = redirect_pc;
               w_clear     = 1'b1;
               w_state_nxt = ST_REQ;
            end else if (w_hs) begin
               w_clear     = 1'b1;
               w_count_inc = 1'b1;
               w_state_nxt = pc_write ? ST_REQ : ST_HALTED;
            end
         end
         default: begin
            w_state_nxt = ST_HALTED;
         end
      endcase
      w_req_nxt  = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_DRAIN);
      // DRAIN keeps the address of the request still in flight.
      w_addr_nxt = (w_state_nxt == ST_DRAIN) ? r_addr : w_pc_nxt;
   end

   // State, PC, request and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_REQ;
         r_pc     <= RESET_PC;
         r_addr   <= RESET_PC;
         r_req    <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_addr   <= w_addr_nxt;
         r_req    <= w_req_nxt;
         r_halted <= (w_state_nxt == ST_HALTED);
         if (w_count_inc) begin
            r_count <= r_count + FU_COUNT_WIDTH'(1);
         end
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign halted      = r_halted;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with an instruction memory model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [15:0] id_instr;
   logic [3:0]  id_opcode;
   logic [15:0] id_pc;
   logic        pc_write;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halted;
   logic [15:0] fetch_count;

   int tests = 0;
   int fails = 0;

   logic [15:0] mem [65536];
   logic        ack_tie   = 1'b0;
   logic        rand_mode = 1'b0;
   int          lat_fixed = 0;
   int          lat_rand  = 0;
   int          wait_cnt;
   int          eff_lat;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_opcode      (id_opcode),
      .id_pc          (id_pc),
      .pc_write       (pc_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack after eff_lat waiting cycles, data read at the presented address.
   assign eff_lat    = rand_mode ? lat_rand : lat_fixed;
   assign imem_ack   = ack_tie | (imem_req & (wait_cnt >= eff_lat));
   assign imem_rdata = mem[imem_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 0;
      end else if (imem_req & imem_ack) begin
         wait_cnt <= 0;
         lat_rand <= $urandom_range(0, 3);
      end else if (imem_req) begin
         wait_cnt <= wait_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      id_ready       = 1'b0;
      pc_write       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      #12;
      chk("rst_req",   16'(imem_req), 16'h0);
      chk("rst_addr",  imem_addr, FU_RESET_PC);
      chk("rst_valid", 16'(id_valid), 16'h0);
      chk("rst_instr", id_instr, 16'h0);
      chk("rst_pc",    id_pc, 16'h0);
      chk("rst_halt",  16'(halted), 16'h0);
      chk("rst_count", fetch_count, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [15:0] exp_pc;
   logic [15:0] exp_count;

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      mem[0] = {OPC_ADD,  12'h123};
      mem[1] = {OPC_SUB,  12'h456};
      mem[2] = {OPC_AND,  12'h789};
      mem[3] = {OPC_ADD,  12'h001};
      mem[4] = {OPC_HALT, 12'h000};

      // Zero-wait memory, decode always ready: three instructions back to back.
      ack_tie = 1'b1;
      do_reset();
      id_ready = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk("zw_req",    16'(imem_req), 16'h1);
         chk("zw_addr",   imem_addr, 16'(i));
         cyc();
         chk("zw_req_lo", 16'(imem_req), 16'h0);
         chk("zw_valid",  16'(id_valid), 16'h1);
         chk("zw_idpc",   id_pc, 16'(i));
         chk("zw_instr",  id_instr, mem[i]);
         chk("zw_opc",    16'(id_opcode), 16'(mem[i][15:12]));
         cyc();
      end
      id_ready = 1'b0;
      chk("zw_count", fetch_count, 16'd3);
      chk("zw_addr3", imem_addr, 16'd3);

      // Decode stalls for five cycles with pc 3 buffered.
      cyc();
      for (int k = 0; k < 5; k++) begin
         chk("st_valid", 16'(id_valid), 16'h1);
         chk("st_idpc",  id_pc, 16'd3);
         chk("st_instr", id_instr, mem[3]);
         chk("st_req",   16'(imem_req), 16'h0);
         chk("st_count", fetch_count, 16'd3);
         cyc();
      end
      id_ready = 1'b1;
      cyc();
      chk("st_count4", fetch_count, 16'd4);
      chk("st_addr4",  imem_addr, 16'd4);

      // HALT at pc 4.
      cyc();
      chk("h_opc",  16'(id_opcode), 16'(OPC_HALT));
      chk("h_idpc", id_pc, 16'd4);
      pc_write = 1'b0;
      cyc();
      pc_write = 1'b1;
      chk("h_halted", 16'(halted), 16'h1);
      chk("h_count",  fetch_count, 16'd5);
      for (int k = 0; k < 20; k++) begin
         chk("h_req",   16'(imem_req), 16'h0);
         chk("h_valid", 16'(id_valid), 16'h0);
         chk("h_stay",  16'(halted), 16'h1);
         chk("h_cnt",   fetch_count, 16'd5);
         cyc();
      end

      // Ack delayed by three cycles.
      ack_tie   = 1'b0;
      lat_fixed = 3;
      do_reset();
      cyc();
      for (int k = 0; k < 4; k++) begin
         chk("dl_req",   16'(imem_req), 16'h1);
         chk("dl_addr",  imem_addr, 16'h0);
         chk("dl_valid", 16'(id_valid), 16'h0);
         cyc();
      end
      chk("dl_valid1", 16'(id_valid), 16'h1);
      chk("dl_instr",  id_instr, mem[0]);
      chk("dl_idpc",   id_pc, 16'h0);

      // Redirect while the fetch of 5 is outstanding.
      lat_fixed = 100;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 16'd5;
      cyc();
      chk("rd_addr5", imem_addr, 16'd5);
      redirect_pc = 16'h0040;
      cyc();
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rd_dreq",   16'(imem_req), 16'h1);
         chk("rd_daddr",  imem_addr, 16'd5);
         chk("rd_dvalid", 16'(id_valid), 16'h0);
         cyc();
      end
      lat_fixed = 0;
      cyc();
      chk("rd_naddr", imem_addr, 16'h0040);
      chk("rd_nreq",  16'(imem_req), 16'h1);
      chk("rd_drop",  16'(id_valid), 16'h0);
      cyc();
      chk("rd_valid", 16'(id_valid), 16'h1);
      chk("rd_idpc",  id_pc, 16'h0040);
      chk("rd_instr", id_instr, mem[16'h0040]);

      // Redirect and ready together in HOLD, then the 0xFFFF wrap.
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      #1;
      chk("rh_valid", 16'(id_valid), 16'h0);
      cyc();
      redirect_valid = 1'b0;
      chk("rh_count", fetch_count, 16'h0);
      chk("rh_addr",  imem_addr, 16'hFFFF);
      cyc();
      chk("wr_idpc", id_pc, 16'hFFFF);
      cyc();
      chk("wr_addr",  imem_addr, 16'h0000);
      chk("wr_count", fetch_count, 16'd1);
      cyc();
      cyc();
      chk("wr_addr1", imem_addr, 16'd1);

      // Reset pulse in DRAIN, with a stale ack right after release.
      lat_fixed      = 100;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0200;
      cyc();
      redirect_valid = 1'b0;
      chk("rp_dreq",  16'(imem_req), 16'h1);
      chk("rp_daddr", imem_addr, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rp_req0",  16'(imem_req), 16'h0);
      chk("rp_addr0", imem_addr, FU_RESET_PC);
      chk("rp_cnt0",  fetch_count, 16'h0);
      ack_tie  = 1'b1;
      id_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      ack_tie = 1'b0;
      chk("rp_req",   16'(imem_req), 16'h1);
      chk("rp_addr",  imem_addr, FU_RESET_PC);
      chk("rp_stale", 16'(id_valid), 16'h0);

      // Random traffic against a program-order model of delivered (pc, word).
      rand_mode = 1'b1;
      do_reset();
      exp_pc    = FU_RESET_PC;
      exp_count = 16'h0;
      for (int c = 0; c < 4000; c++) begin
         chk("rn_count", fetch_count, exp_count);
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 16'hFFFF;
            1:       redirect_pc = 16'hFFFE;
            default: redirect_pc = 16'($urandom);
         endcase
         #1;
         if (redirect_valid) chk("rn_gate", 16'(id_valid), 16'h0);
         if (id_valid && id_ready) begin
            chk("rn_idpc",  id_pc, exp_pc);
            chk("rn_instr", id_instr, mem[exp_pc]);
            exp_pc    = exp_pc + 16'd1;
            exp_count = exp_count + 16'd1;
         end
         if (redirect_valid) exp_pc = redirect_pc;
         cyc();
      end
      redirect_valid = 1'b0;
      chk("rn_final", fetch_count, exp_count);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
